// File: rtl/vending_machine_top.sv
// Vending machine controller: button debouncers, credit/price FSM, inventory, BCD displays, status LEDs.
// Optional tone output built only when AUDIO_EN is defined; otherwise audio_out is tied low.

module vm_debouncer #(
  parameter int CNTR_MAX = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press_pulse
);
  localparam int CW = (CNTR_MAX < 2) ? 1 : $clog2(CNTR_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNTR_MAX - 1);

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic          db_q, db_d, pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = '0;
    // Output follows the synced input only after CNTR_MAX consecutive disagreeing cycles.
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) db_d = sync2_q;
      else                   cnt_d = cnt_q + 1'b1;
    end
    pulse_d = db_d & ~db_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign press_pulse = pulse_q;
endmodule

module vm_inventory #(
  parameter int STOCK_INIT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_en,
  input  logic [1:0]  dec_item,
  input  logic        restock_en,
  input  logic [1:0]  sel,
  output logic [15:0] stock_all,
  output logic [3:0]  stock_level
);
  logic [15:0] stock_q, stock_d;

  always_comb begin
    stock_d = stock_q;
    for (int i = 0; i < 4; i++) begin
      if (restock_en) begin
        stock_d[i*4 +: 4] = 4'(STOCK_INIT);
      end else if (dec_en && (dec_item == 2'(i)) && (stock_q[i*4 +: 4] != 4'd0)) begin
        stock_d[i*4 +: 4] = stock_q[i*4 +: 4] - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stock_q <= {4{4'(STOCK_INIT)}};
    else     stock_q <= stock_d;
  end

  assign stock_all   = stock_q;
  assign stock_level = stock_q[{sel, 2'b00} +: 4];
endmodule

module vm_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        coin1_p,
  input  logic        coin2_p,
  input  logic        coin5_p,
  input  logic        purchase_p,
  input  logic [1:0]  sw_item,
  input  logic        restock,
  input  logic [15:0] stock_all,
  output logic [2:0]  state,
  output logic [7:0]  credit,
  output logic [7:0]  change_due,
  output logic [7:0]  price_sel,
  output logic        vend_pulse,
  output logic        error_flag,
  output logic        dec_en,
  output logic [1:0]  dec_item,
  output logic        restock_en
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, CHECK = 3'd1, VEND = 3'd2, CHANGE = 3'd3, RESTOCK = 3'd4, ERROR = 3'd5
  } state_t;

  function automatic logic [3:0] stock_of(input logic [15:0] all, input logic [1:0] item);
    return all[{item, 2'b00} +: 4];
  endfunction

  function automatic logic [7:0] price_of(input logic [1:0] item, input logic [3:0] stk);
    logic [7:0] base;
    case (item)
      2'd0:    base = 8'd3;
      2'd1:    base = 8'd4;
      2'd2:    base = 8'd6;
      default: base = 8'd5;
    endcase
    if (stk == 4'd0)                     return 8'd0;
    else if (stk == 4'd1 || stk == 4'd2) return base + 8'd1;
    else                                 return base;
  endfunction

  function automatic logic [7:0] sat99(input logic [7:0] c, input logic [3:0] add);
    logic [8:0] s;
    s = {1'b0, c} + {5'b0, add};
    return (s > 9'd99) ? 8'd99 : s[7:0];
  endfunction

  state_t     state_q, state_d;
  logic [7:0] credit_q, credit_d, change_q, change_d;
  logic [1:0] item_q, item_d;
  logic       vend_q, vend_d, err_q, err_d;
  logic [3:0] coin_sum, stk_sw;
  logic [7:0] price_sw, price_item;

  assign coin_sum   = {3'b0, coin1_p} + {2'b0, coin2_p, 1'b0} + (coin5_p ? 4'd5 : 4'd0);
  assign stk_sw     = stock_of(stock_all, sw_item);
  assign price_sw   = price_of(sw_item, stk_sw);
  assign price_item = price_of(item_q, stock_of(stock_all, item_q));

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    change_d = change_q;
    item_d   = item_q;
    case (state_q)
      IDLE: begin
        credit_d = sat99(credit_q, coin_sum);
        if (purchase_p)   state_d = CHECK;
        else if (restock) state_d = RESTOCK;
      end
      CHECK: begin
        item_d = sw_item;
        if (stk_sw == 4'd0 || credit_q < price_sw) state_d = ERROR;
        else                                       state_d = VEND;
      end
      VEND: begin
        credit_d = credit_q - price_item;
        state_d  = CHANGE;
      end
      CHANGE: begin
        change_d = credit_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Pulses register together with the state they belong to.
    vend_d = (state_d == VEND);
    err_d  = (state_d == ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      credit_q <= 8'd0;
      change_q <= 8'd0;
      item_q   <= 2'd0;
      vend_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      change_q <= change_d;
      item_q   <= item_d;
      vend_q   <= vend_d;
      err_q    <= err_d;
    end
  end

  assign state      = state_q;
  assign credit     = credit_q;
  assign change_due = change_q;
  assign price_sel  = price_sw;
  assign vend_pulse = vend_q;
  assign error_flag = err_q;
  assign dec_en     = (state_q == VEND);
  assign dec_item   = item_q;
  assign restock_en = (state_q == RESTOCK);
endmodule

module vending_machine_top #(
  parameter int DEBOUNCE_MAX = 500000,
  parameter int STOCK_INIT   = 5,
  parameter int TONE_DIV     = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_coin1,
  input  logic       btn_coin2,
  input  logic       btn_coin5,
  input  logic       btn_purchase,
  input  logic [1:0] sw_item,
  input  logic       restock,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic [3:0] stock_level,
  output logic [7:0] leds,
  output logic       audio_out
);
  function automatic logic [7:0] to_bcd(input logic [7:0] v);
    logic [3:0] t, o;
    t = 4'(v / 8'd10);
    o = 4'(v % 8'd10);
    return {t, o};
  endfunction

  logic        coin1_p, coin2_p, coin5_p, purchase_p;
  logic [2:0]  state;
  logic [7:0]  credit, change_due, price_sel;
  logic        vend_pulse, error_flag, dec_en, restock_en;
  logic [1:0]  dec_item;
  logic [15:0] stock_all;
  logic [3:0]  vend_str_q, vend_str_d, err_str_q, err_str_d;

  vm_debouncer #(.CNTR_MAX(DEBOUNCE_MAX)) db0 (.clk(clk), .rst(rst), .btn_in(btn_coin1),    .press_pulse(coin1_p));
  vm_debouncer #(.CNTR_MAX(DEBOUNCE_MAX)) db1 (.clk(clk), .rst(rst), .btn_in(btn_coin2),    .press_pulse(coin2_p));
  vm_debouncer #(.CNTR_MAX(DEBOUNCE_MAX)) db2 (.clk(clk), .rst(rst), .btn_in(btn_coin5),    .press_pulse(coin5_p));
  vm_debouncer #(.CNTR_MAX(DEBOUNCE_MAX)) db3 (.clk(clk), .rst(rst), .btn_in(btn_purchase), .press_pulse(purchase_p));

  vm_controller ctrl (
    .clk(clk), .rst(rst),
    .coin1_p(coin1_p), .coin2_p(coin2_p), .coin5_p(coin5_p), .purchase_p(purchase_p),
    .sw_item(sw_item), .restock(restock), .stock_all(stock_all),
    .state(state), .credit(credit), .change_due(change_due), .price_sel(price_sel),
    .vend_pulse(vend_pulse), .error_flag(error_flag),
    .dec_en(dec_en), .dec_item(dec_item), .restock_en(restock_en)
  );

  vm_inventory #(.STOCK_INIT(STOCK_INIT)) inv (
    .clk(clk), .rst(rst), .dec_en(dec_en), .dec_item(dec_item), .restock_en(restock_en),
    .sel(sw_item), .stock_all(stock_all), .stock_level(stock_level)
  );

  assign {digit3, digit2} = to_bcd(credit);
  assign {digit1, digit0} = to_bcd(price_sel);

  // Stretch single-cycle events so they are visible on the LEDs.
  always_comb begin
    vend_str_d = (vend_str_q != 4'd0) ? vend_str_q - 4'd1 : 4'd0;
    err_str_d  = (err_str_q  != 4'd0) ? err_str_q  - 4'd1 : 4'd0;
    if (vend_pulse) vend_str_d = 4'd8;
    if (error_flag) err_str_d  = 4'd8;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vend_str_q <= 4'd0;
      err_str_q  <= 4'd0;
    end else begin
      vend_str_q <= vend_str_d;
      err_str_q  <= err_str_d;
    end
  end

  assign leds = {state, (credit != 8'd0), (stock_level == 4'd0), (change_due != 8'd0),
                 (err_str_q != 4'd0), (vend_str_q != 4'd0)};

`ifdef AUDIO_EN
  localparam int DW = (TONE_DIV < 2) ? 1 : $clog2(TONE_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TONE_DIV - 1);

  logic [16:0]   win_q, win_d;
  logic [DW-1:0] div_q, div_d;
  logic          audio_q, audio_d;

  always_comb begin
    win_d   = (win_q != 17'd0) ? win_q - 17'd1 : 17'd0;
    div_d   = '0;
    audio_d = 1'b0;
    if (win_q != 17'd0) begin
      audio_d = audio_q;
      if (div_q == DIV_LAST) audio_d = ~audio_q;
      else                   div_d   = div_q + 1'b1;
    end
    if (vend_pulse || error_flag) win_d = 17'h10000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q   <= 17'd0;
      div_q   <= '0;
      audio_q <= 1'b0;
    end else begin
      win_q   <= win_d;
      div_q   <= div_d;
      audio_q <= audio_d;
    end
  end

  assign audio_out = audio_q;
`else
  assign audio_out = (TONE_DIV < 0);
`endif
endmodule

// File: tb/tb_vending_machine_top.sv
// Directed bench for vending_machine_top with a short debounce window.

module tb_vending_machine_top;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_coin1 = 1'b0, btn_coin2 = 1'b0, btn_coin5 = 1'b0, btn_purchase = 1'b0;
  logic [1:0] sw_item = 2'd0;
  logic       restock = 1'b0;
  logic [3:0] digit3, digit2, digit1, digit0, stock_level;
  logic [7:0] leds;
  logic       audio_out;

  int n_checks = 0;
  int n_fail   = 0;
  int vend_run = 0;
  int vend_max = 0;

  vending_machine_top #(.DEBOUNCE_MAX(2), .STOCK_INIT(5), .TONE_DIV(4)) dut (
    .clk(clk), .rst(rst),
    .btn_coin1(btn_coin1), .btn_coin2(btn_coin2), .btn_coin5(btn_coin5), .btn_purchase(btn_purchase),
    .sw_item(sw_item), .restock(restock),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .stock_level(stock_level), .leds(leds), .audio_out(audio_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (dut.ctrl.vend_pulse === 1'b1) vend_run = vend_run + 1;
    else vend_run = 0;
    if (vend_run > vend_max) vend_max = vend_run;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic c1, input logic c2, input logic c5, input logic p);
    btn_coin1 = c1; btn_coin2 = c2; btn_coin5 = c5; btn_purchase = p;
    tick(4);
    btn_coin1 = 1'b0; btn_coin2 = 1'b0; btn_coin5 = 1'b0; btn_purchase = 1'b0;
    tick(6);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    n_checks++;
    if ({digit3, digit2} !== 8'h00) begin n_fail++; $display("FAIL reset_credit got %h want 00", {digit3, digit2}); end
    n_checks++;
    if (leds !== 8'h00) begin n_fail++; $display("FAIL reset_leds got %h want 00", leds); end
    n_checks++;
    if (stock_level !== 4'd5) begin n_fail++; $display("FAIL reset_stock got %0d want 5", stock_level); end
    n_checks++;
    if (dut.ctrl.change_due !== 8'd0) begin n_fail++; $display("FAIL reset_change got %0d want 0", dut.ctrl.change_due); end
    n_checks++;
    if (audio_out !== 1'b0) begin n_fail++; $display("FAIL reset_audio got %b want 0", audio_out); end
  endtask

  task automatic test_coin;
    press(0, 0, 1, 0);
    n_checks++;
    if ({digit3, digit2} !== 8'h05) begin n_fail++; $display("FAIL coin5_credit got %h want 05", {digit3, digit2}); end
    n_checks++;
    if ({digit1, digit0} !== 8'h03) begin n_fail++; $display("FAIL price_item0 got %h want 03", {digit1, digit0}); end
  endtask

  task automatic test_purchase;
    sw_item = 2'd0;
    btn_purchase = 1'b1;
    tick(4);
    btn_purchase = 1'b0;
    tick(8);
    n_checks++;
    if (dut.ctrl.vend_pulse !== 1'b0) begin n_fail++; $display("FAIL buy_vend_low got %b want 0", dut.ctrl.vend_pulse); end
    n_checks++;
    if ({digit3, digit2} !== 8'h02) begin n_fail++; $display("FAIL buy_credit got %h want 02", {digit3, digit2}); end
    n_checks++;
    if (dut.ctrl.change_due !== 8'd2) begin n_fail++; $display("FAIL buy_change got %0d want 2", dut.ctrl.change_due); end
    n_checks++;
    if (stock_level !== 4'd4) begin n_fail++; $display("FAIL buy_stock got %0d want 4", stock_level); end
    n_checks++;
    if (leds[2:0] !== 3'b101) begin n_fail++; $display("FAIL buy_leds got %b want 101", leds[2:0]); end
  endtask

  task automatic test_error;
    logic found;
    found = 1'b0;
    sw_item = 2'd2;
    tick(1);
    n_checks++;
    if ({digit1, digit0} !== 8'h06) begin n_fail++; $display("FAIL price_item2 got %h want 06", {digit1, digit0}); end
    btn_purchase = 1'b1;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (i == 3) btn_purchase = 1'b0;
      if (dut.ctrl.error_flag === 1'b1) begin
        found = 1'b1;
        n_checks++;
        if (leds[7:5] !== 3'd5) begin n_fail++; $display("FAIL err_state got %0d want 5", leds[7:5]); end
        @(negedge clk);
        n_checks++;
        if (leds[7:5] !== 3'd0 || dut.ctrl.error_flag !== 1'b0) begin
          n_fail++; $display("FAIL err_next got state %0d flag %b want 0 0", leds[7:5], dut.ctrl.error_flag);
        end
      end
    end
    btn_purchase = 1'b0;
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL err_seen got 0 want 1"); end
    tick(8);
    n_checks++;
    if ({digit3, digit2} !== 8'h02) begin n_fail++; $display("FAIL err_credit got %h want 02", {digit3, digit2}); end
  endtask

  task automatic test_deplete;
    sw_item = 2'd0;
    press(0, 0, 1, 0);
    press(0, 0, 1, 0);
    n_checks++;
    if ({digit3, digit2} !== 8'h12) begin n_fail++; $display("FAIL dep_credit12 got %h want 12", {digit3, digit2}); end
    press(0, 0, 0, 1);
    press(0, 0, 0, 1);
    n_checks++;
    if (stock_level !== 4'd2 || {digit1, digit0} !== 8'h04) begin
      n_fail++; $display("FAIL dep_stock2 got stock %0d price %h want 2 04", stock_level, {digit1, digit0});
    end
    n_checks++;
    if ({digit3, digit2} !== 8'h06) begin n_fail++; $display("FAIL dep_credit6 got %h want 06", {digit3, digit2}); end
    press(0, 0, 0, 1);
    press(0, 0, 1, 0);
    press(0, 0, 0, 1);
    n_checks++;
    if (stock_level !== 4'd0 || {digit1, digit0} !== 8'h00 || leds[3] !== 1'b1) begin
      n_fail++; $display("FAIL dep_stock0 got stock %0d price %h led3 %b want 0 00 1", stock_level, {digit1, digit0}, leds[3]);
    end
    n_checks++;
    if (dut.ctrl.change_due !== 8'd3) begin n_fail++; $display("FAIL dep_change got %0d want 3", dut.ctrl.change_due); end
    press(0, 0, 0, 1);
    n_checks++;
    if (leds[1] !== 1'b1) begin n_fail++; $display("FAIL dep_err_led got %b want 1", leds[1]); end
    n_checks++;
    if (stock_level !== 4'd0 || {digit3, digit2} !== 8'h03) begin
      n_fail++; $display("FAIL dep_empty_buy got stock %0d credit %h want 0 03", stock_level, {digit3, digit2});
    end
  endtask

  task automatic test_restock_coins;
    restock = 1'b1;
    tick(1);
    restock = 1'b0;
    tick(3);
    n_checks++;
    if (dut.inv.stock_all !== 16'h5555) begin n_fail++; $display("FAIL restock got %h want 5555", dut.inv.stock_all); end
    press(1, 1, 0, 0);
    n_checks++;
    if ({digit3, digit2} !== 8'h06) begin n_fail++; $display("FAIL coin1_2 got %h want 06", {digit3, digit2}); end
    for (int i = 0; i < 20; i++) press(0, 0, 1, 0);
    n_checks++;
    if ({digit3, digit2} !== 8'h99) begin n_fail++; $display("FAIL saturate got %h want 99", {digit3, digit2}); end
  endtask

  task automatic test_reset_mid_vend;
    logic found;
    found = 1'b0;
    sw_item = 2'd0;
    btn_purchase = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (dut.ctrl.state === 3'd2) found = 1'b1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL midvend_reach got 0 want 1"); end
    rst = 1'b1;
    btn_purchase = 1'b0;
    tick(1);
    n_checks++;
    if (dut.ctrl.credit !== 8'd0 || dut.ctrl.state !== 3'd0) begin
      n_fail++; $display("FAIL midvend_rst got credit %0d state %0d want 0 0", dut.ctrl.credit, dut.ctrl.state);
    end
    n_checks++;
    if (dut.inv.stock_all !== 16'h5555) begin n_fail++; $display("FAIL midvend_stock got %h want 5555", dut.inv.stock_all); end
    rst = 1'b0;
    tick(8);
    n_checks++;
    if (stock_level !== 4'd5 || leds !== 8'h00) begin
      n_fail++; $display("FAIL midvend_after got stock %0d leds %h want 5 00", stock_level, leds);
    end
  endtask

  initial begin
    test_reset;
    test_coin;
    test_purchase;
    test_error;
    test_deplete;
    test_restock_coins;
    test_reset_mid_vend;
    n_checks++;
    if (vend_max !== 1) begin n_fail++; $display("FAIL vend_width got %0d want 1", vend_max); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vending_machine_top.md
Name: vending_machine_top

Overview:
Top level of a coin-operated vending machine controller. It debounces four push-buttons, accumulates credit, prices and vends one of four items from an on-chip inventory, and computes change. It drives BCD display digits, a stock indicator, status LEDs and a tone output. It is the board-level wrapper; all submodules sit below it.

Parameters:
DEBOUNCE_MAX, 500000, consecutive stable cycles before a debounced button changes state; propagated to debouncer instances db0..db3 as CNTR_MAX.
STOCK_INIT, 5, per-item stock after reset.
TONE_DIV, 50000, half-period in clocks of audio_out square wave.

Ports:
clk  in  1  system clock
rst  in  1  reset
btn_coin1  in  1  raw $1 coin button
btn_coin2  in  1  raw $2 coin button
btn_coin5  in  1  raw $5 coin button
btn_purchase  in  1  raw purchase button
sw_item  in  2  selected item 0..3
restock  in  1  level restock request
digit3, digit2  out  4 each  credit, BCD tens/ones
digit1, digit0  out  4 each  selected item price, BCD tens/ones
stock_level  out  4  stock of selected item
leds  out  8  status
audio_out  out  1  tone output

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values: credit=0, change_due=0, every item stock=STOCK_INIT, FSM=IDLE, vend_pulse=0, error_flag=0, leds=0, audio_out=0.
- Debouncers db0..db3 (coin1, coin2, coin5, purchase):
  - 2-FF synchronizer feeds a counter.
  - Debounced output takes the synced value after it differs from the current output for CNTR_MAX consecutive cycles.
  - A rising-edge detector emits one 1-cycle pulse per press.
  - Press-to-pulse latency is at most CNTR_MAX+3 cycles.
- Credit: 8-bit register in controller instance ctrl.
  - Coin pulses are accepted only in IDLE and add 1, 2 or 5.
  - Simultaneous coin pulses sum.
  - Credit saturates at 99.
- Price (base): item0=3, item1=4, item2=6, item3=5.
  - Price is base+1 when that item's stock is 1 or 2.
  - Price is 0 when that item's stock is 0.
- Controller FSM, 3-bit state register ctrl.state:
  - IDLE=0: a purchase pulse goes to CHECK.
  - CHECK=1: if stock=0 or credit<price, go to ERROR; else go to VEND.
  - VEND=2: vend_pulse=1 for exactly this cycle; credit -= price; inventory instance inv decrements the selected item's stock; go to CHANGE.
  - CHANGE=3: change_due <= credit (remaining credit); credit is NOT cleared; go to IDLE.
  - RESTOCK=4: entered from IDLE when restock=1; all stocks set to STOCK_INIT; return to IDLE.
  - ERROR=5: error_flag=1 for exactly this one cycle, registered together with the state entering ERROR; credit and stock unchanged; next cycle IDLE.
- Purchase completes within 3 cycles of the purchase pulse; vend_pulse is never high longer than 1 cycle.
- sw_item is sampled in CHECK; changing it afterwards does not affect the transaction.
- Stock never underflows. Restock is ignored outside IDLE.
- stock_level = inv.stock_level, the stock of sw_item, combinational.
- Displays: binary to BCD, combinational.
- leds:
  - [0] vend_pulse, stretched 8 cycles
  - [1] error_flag, stretched 8 cycles
  - [2] change_due≠0
  - [3] selected item out of stock
  - [4] credit≠0
  - [7:5] FSM state

Optional Feature:
AUDIO_EN defined: audio_out toggles every TONE_DIV cycles for 2^16 cycles after each vend or error, and is 0 otherwise. AUDIO_EN undefined: audio_out is constant 0 and no tone logic is built.

Test Plan:
- DEBOUNCE_MAX=2. Reset 3 cycles, then press coin5 for 4 cycles, wait 6 cycles -> credit=5, digit3/digit2=0/5.
- sw_item=0, press purchase 4 cycles, wait 8 -> vend_pulse=0, credit=2, change_due=2, stock_level=4.
- sw_item=2 with credit 2, press purchase -> on error_flag rise, state=5 for one cycle, then 0; credit stays 2.
- Deplete item0 to stock 2 -> price shows 4; at stock 0 a purchase goes to ERROR and stock stays 0.
- Assert restock in IDLE -> all stocks=5; coin1+coin2 pressed together -> credit +3; repeated coin5 saturates credit at 99.
- Assert rst mid-VEND -> next cycle credit=0, state=0, all stocks=5.
